// File: rtl/trisc_ctrl.sv
// TRISC fetch/decode/execute sequencer driving the accumulator strobes.
// Optional single-step port enabled by defining TRISC_CTRL_STEP_EN.
module trisc_ctrl #(
    parameter int N    = 4,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            reset,
`ifdef TRISC_CTRL_STEP_EN
    input  logic            step,
`endif
    input  logic [OP_W+N-1:0] instr,
    input  logic [N-1:0]    acc_q,
    output logic [N-1:0]    pc,
    output logic            acc_clear,
    output logic            acc_load,
    output logic            acc_inc,
    output logic            acc_ab,
    output logic [N-1:0]    acc_b,
    output logic            halted,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        HALT   = 2'd3
    } state_t;

    localparam logic [OP_W-1:0] OP_CLR  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LDI  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LDA  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_INC  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JMP  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JZ   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(7);

    state_t              state, state_d;
    logic [OP_W+N-1:0]   ir, ir_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [N-1:0]        opnd_q, opnd_d;
    logic [N-1:0]        pc_d, acc_b_d;
    logic                clr_d, ld_d, inc_d, ab_d;
    logic                go;

`ifdef TRISC_CTRL_STEP_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            ir        <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            pc        <= '0;
            acc_b     <= '0;
            acc_clear <= 1'b0;
            acc_load  <= 1'b0;
            acc_inc   <= 1'b0;
            acc_ab    <= 1'b0;
        end else begin
            state     <= state_d;
            ir        <= ir_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            pc        <= pc_d;
            acc_b     <= acc_b_d;
            acc_clear <= clr_d;
            acc_load  <= ld_d;
            acc_inc   <= inc_d;
            acc_ab    <= ab_d;
        end
    end

    // Strobes are decoded from ir on the DECODE edge so they land
    // registered exactly in the EXEC cycle.
    always_comb begin
        state_d = state;
        ir_d    = ir;
        op_d    = op_q;
        opnd_d  = opnd_q;
        pc_d    = pc;
        acc_b_d = acc_b;
        clr_d   = 1'b0;
        ld_d    = 1'b0;
        inc_d   = 1'b0;
        ab_d    = 1'b0;
        unique case (state)
            FETCH: begin
                if (go) begin
                    ir_d    = instr;
                    pc_d    = pc + N'(1);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                op_d    = ir[OP_W+N-1:N];
                opnd_d  = ir[N-1:0];
                acc_b_d = ir[N-1:0];
                state_d = EXEC;
                case (ir[OP_W+N-1:N])
                    OP_CLR: clr_d = 1'b1;
                    OP_LDI: begin
                        ld_d = 1'b1;
                        ab_d = 1'b1;
                    end
                    OP_LDA: ld_d  = 1'b1;
                    OP_INC: inc_d = 1'b1;
                    default: ;
                endcase
            end
            EXEC: begin
                state_d = FETCH;
                case (op_q)
                    OP_JMP:  pc_d = opnd_q;
                    OP_JZ: begin
                        if (acc_q == '0) pc_d = opnd_q;
                    end
                    OP_HALT: state_d = HALT;
                    default: ;
                endcase
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign halted  = (state == HALT);
    assign state_o = state;

endmodule
